// File: rtl/conv_calc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : conv_calc_pipe
// Description : Three-stage pipelined convolution calculator. Each accepted
//               beat carries one FILTER_SIZE x FILTER_SIZE unsigned window.
//               The block computes CHANNEL_LEN signed dot products against
//               runtime-loadable weights, adds a per-channel bias, then
//               requantises with an arithmetic shift and saturation.
//               Optional macro CONV_CALC_RELU_EN clamps negative results
//               to zero in the last stage.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_calc_pipe #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 5,
  parameter int CHANNEL_LEN = 3,
  parameter int BIAS_BITS   = 16,
  parameter int ACC_BITS    = 24,
  parameter int SHIFT       = 8,
  parameter int OUT_BITS    = 12
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           valid_in,
  output logic                                           ready_in,
  input  logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0]   data_in,
  output logic                                           valid_out,
  input  logic                                           ready_out,
  output logic [CHANNEL_LEN*OUT_BITS-1:0]                conv_out,
  input  logic                                           w_we,
  input  logic [$clog2(CHANNEL_LEN)-1:0]                 w_ch,
  input  logic [$clog2(FILTER_SIZE*FILTER_SIZE)-1:0]     w_tap,
  input  logic [DATA_BITS-1:0]                           w_data,
  input  logic                                           b_we,
  input  logic [BIAS_BITS-1:0]                           b_data,
  output logic                                           busy,
  output logic                                           cfg_err
);

  localparam int TAPS      = FILTER_SIZE * FILTER_SIZE;
  localparam int PROD_BITS = 2 * DATA_BITS + 1;

  // Saturation bounds expressed at accumulator width; min is the one's
  // complement of max, i.e. -2^(OUT_BITS-1).
  localparam logic signed [ACC_BITS-1:0] c_sat_max = ACC_BITS'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] c_sat_min = ~c_sat_max;

  // Coefficient storage
  logic signed [DATA_BITS-1:0] r_weight [CHANNEL_LEN][TAPS];
  logic signed [BIAS_BITS-1:0] r_bias   [CHANNEL_LEN];

  // Pipeline state
  logic                        r_s1_valid;
  logic                        r_s2_valid;
  logic                        r_s3_valid;
  logic signed [PROD_BITS-1:0] r_s1_prod [CHANNEL_LEN][TAPS];
  logic signed [ACC_BITS-1:0]  r_s2_acc  [CHANNEL_LEN];
  logic [CHANNEL_LEN*OUT_BITS-1:0] r_conv_out;
  logic                        r_cfg_err;

  // Combinational datapath
  logic signed [PROD_BITS-1:0] w_prod  [CHANNEL_LEN][TAPS];
  logic signed [ACC_BITS-1:0]  w_sum   [CHANNEL_LEN];
  logic signed [ACC_BITS-1:0]  w_shift [CHANNEL_LEN];
  logic [CHANNEL_LEN*OUT_BITS-1:0] w_result;

  logic w_adv;
  logic w_busy;
  logic w_cfg_idle;
  logic w_wch_ok;
  logic w_wtap_ok;
  logic w_w_accept;
  logic w_b_accept;
  logic w_cfg_reject;

  // Whole pipeline moves together; it only freezes when the output holds an
  // unconsumed result.
  assign w_adv     = ~r_s3_valid | ready_out;
  assign w_busy    = r_s1_valid | r_s2_valid | r_s3_valid;
  assign ready_in  = w_adv;
  assign busy      = w_busy;
  assign valid_out = r_s3_valid;
  assign conv_out  = r_conv_out;
  assign cfg_err   = r_cfg_err;

  // Config writes are only safe when no beat could observe a half-updated set.
  assign w_cfg_idle   = ~w_busy & ~valid_in;
  assign w_wch_ok     = 32'(w_ch) < CHANNEL_LEN;
  assign w_wtap_ok    = 32'(w_tap) < TAPS;
  assign w_w_accept   = w_we & w_cfg_idle & w_wch_ok & w_wtap_ok;
  assign w_b_accept   = b_we & w_cfg_idle & w_wch_ok;
  assign w_cfg_reject = (w_we & ~(w_cfg_idle & w_wch_ok & w_wtap_ok))
                      | (b_we & ~(w_cfg_idle & w_wch_ok));

  // Stage-1 multipliers: pixel zero-extended so it stays positive as signed.
  generate
    for (genvar c = 0; c < CHANNEL_LEN; c++) begin : g_ch
      for (genvar k = 0; k < TAPS; k++) begin : g_tap
        assign w_prod[c][k] =
          $signed({{(DATA_BITS + 1){1'b0}}, data_in[k*DATA_BITS +: DATA_BITS]})
          * PROD_BITS'(r_weight[c][k]);
      end
    end
  endgenerate

  // Stage-2 adder tree: bias seeds the sum, every product sign-extended.
  always_comb begin
    for (int c = 0; c < CHANNEL_LEN; c++) begin
      w_sum[c] = ACC_BITS'(r_bias[c]);
      for (int k = 0; k < TAPS; k++) begin
        w_sum[c] = w_sum[c] + ACC_BITS'(r_s1_prod[c][k]);
      end
    end
  end

  // Stage-3 requantisation: floor shift, then clamp into the output range.
  always_comb begin
    w_result = '0;
    for (int c = 0; c < CHANNEL_LEN; c++) begin
      w_shift[c] = r_s2_acc[c] >>> SHIFT;
      if (w_shift[c] > c_sat_max) begin
        w_result[c*OUT_BITS +: OUT_BITS] = c_sat_max[OUT_BITS-1:0];
      end else if (w_shift[c] < c_sat_min) begin
        w_result[c*OUT_BITS +: OUT_BITS] = c_sat_min[OUT_BITS-1:0];
      end else begin
        w_result[c*OUT_BITS +: OUT_BITS] = w_shift[c][OUT_BITS-1:0];
      end
`ifdef CONV_CALC_RELU_EN
      if (w_shift[c] < 0) begin
        w_result[c*OUT_BITS +: OUT_BITS] = '0;
      end
`endif
    end
  end

  // Coefficient registers: cleared on reset, written only when accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_LEN; c++) begin
        r_bias[c] <= '0;
        for (int k = 0; k < TAPS; k++) begin
          r_weight[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CHANNEL_LEN; c++) begin
        if (w_b_accept && (32'(w_ch) == c)) begin
          r_bias[c] <= b_data;
        end
        for (int k = 0; k < TAPS; k++) begin
          if (w_w_accept && (32'(w_ch) == c) && (32'(w_tap) == k)) begin
            r_weight[c][k] <= w_data;
          end
        end
      end
    end
  end

  // Stage valid flags and the config error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_reject;
      if (w_adv) begin
        r_s1_valid <= valid_in;
        r_s2_valid <= r_s1_valid;
        r_s3_valid <= r_s2_valid;
      end
    end
  end

  // Datapath registers for S1/S2; contents are qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_prod <= w_prod;
      r_s2_acc  <= w_sum;
    end
  end

  // Output register: updated only with a real result so bubbles keep it stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conv_out <= '0;
    end else if (w_adv && r_s2_valid) begin
      r_conv_out <= w_result;
    end
  end

endmodule
`default_nettype wire
